// File: rtl/datamem_pkg.sv
// Shared types and defaults for the data_mem_param data memory.
// Optional feature macro used by the top: DATAMEM_REGOUT_EN (registered read).
package datamem_pkg;

  // Default geometry of the CPU data store.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  // Init sequencer states: clear the array, load presets, then serve the core.
  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_PRESET = 2'd1,
    S_READY  = 2'd2
  } state_t;

  // Number of words addressed by an addr_w-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/datamem_init_seq.sv
// Init sequencer for data_mem_param: after reset or Clear it writes 0 to
// every word, then loads up to two preset constants, then raises ready.
module datamem_init_seq
  import datamem_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int NUM_PRESET   = 2,
  parameter int PRESET0_ADDR = 16,
  parameter int PRESET0_DATA = 128,
  parameter int PRESET1_ADDR = 244,
  parameter int PRESET1_DATA = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data,
  output logic              ready
);

  localparam int DEPTH = depth_of(ADDR_W);
  // One extra bit so the terminal compare against DEPTH-1 can never wrap.
  localparam int PTR_W = ADDR_W + 1;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               pidx_q, pidx_d;

  // Next-state logic and init write port.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pidx_d    = pidx_q;
    init_we   = 1'b0;
    init_addr = ptr_q[ADDR_W-1:0];
    init_data = '0;

    if (Clear) begin
      // Clear wins over everything, including an in-progress clear.
      state_d = S_CLEAR;
      ptr_d   = '0;
      pidx_d  = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          init_we = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          if (ptr_q == PTR_W'(DEPTH - 1)) begin
            state_d = (NUM_PRESET == 0) ? S_READY : S_PRESET;
            pidx_d  = 1'b0;
          end
        end
        S_PRESET: begin
          init_we = 1'b1;
          if (pidx_q == 1'b0) begin
            init_addr = ADDR_W'(PRESET0_ADDR);
            init_data = DATA_W'(PRESET0_DATA);
          end else begin
            init_addr = ADDR_W'(PRESET1_ADDR);
            init_data = DATA_W'(PRESET1_DATA);
          end
          if (int'(pidx_q) == NUM_PRESET - 1) begin
            state_d = S_READY;
          end else begin
            pidx_d = 1'b1;
          end
        end
        S_READY: begin
          state_d = S_READY;
        end
        default: begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          pidx_d  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state registers; async reset restarts the clear from addr 0.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      pidx_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pidx_q  <= pidx_d;
    end
  end

  // Ready decodes the state flop only, so it has no path from any input.
  assign ready = (state_q == S_READY);

endmodule

// File: rtl/data_mem_param.sv
// data_mem_param: DATA_W x 2**ADDR_W single-port data RAM for the CPU
// load/store unit, with a built-in clear/preset sequencer, Ready and a
// sticky dropped-write flag.
// Optional feature: define DATAMEM_REGOUT_EN for a registered (1-cycle)
// read; otherwise the read is combinational.
module data_mem_param
  import datamem_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int NUM_PRESET   = 2,
  parameter int PRESET0_ADDR = 16,
  parameter int PRESET0_DATA = 128,
  parameter int PRESET1_ADDR = 244,
  parameter int PRESET1_DATA = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] DataAddress,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Ready,
  output logic              WrDropped
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] core_mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              ready;

  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              wr_dropped_q, wr_dropped_d;
  logic [DATA_W-1:0] rd_word;

  datamem_init_seq #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .NUM_PRESET   (NUM_PRESET),
    .PRESET0_ADDR (PRESET0_ADDR),
    .PRESET0_DATA (PRESET0_DATA),
    .PRESET1_ADDR (PRESET1_ADDR),
    .PRESET1_DATA (PRESET1_DATA)
  ) u_init_seq (
    .Clk       (Clk),
    .Reset     (Reset),
    .Clear     (Clear),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .ready     (ready)
  );

  // Write port mux: the sequencer owns the port until Ready; user writes
  // are accepted only in Ready with no Clear in the same cycle.
  always_comb begin
    user_we      = WriteEn & ready & ~Clear;
    mem_we       = init_we | user_we;
    mem_addr     = init_we ? init_addr : DataAddress;
    mem_data     = init_we ? init_data : DataIn;
    wr_dropped_d = wr_dropped_q | (WriteEn & (~ready | Clear));
  end

  // Array write; read-first because reads below see the pre-edge contents.
  // NOTE: the array has no reset; the sequencer rewrites every word after
  // reset, so resetting it would only cost logic.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      core_mem[mem_addr] <= mem_data;
    end
  end

  // Sticky dropped-write flag, cleared only by Reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_dropped_q <= 1'b0;
    end else begin
      wr_dropped_q <= wr_dropped_d;
    end
  end

  assign rd_word   = ready ? core_mem[DataAddress] : '0;
  assign Ready     = ready;
  assign WrDropped = wr_dropped_q;

`ifdef DATAMEM_REGOUT_EN
  logic [DATA_W-1:0] dout_q, dout_d;

  assign dout_d = rd_word;

  // Registered read: the word sampled at an edge is shown after that edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  // Gate with Ready so the output is 0 right after a Clear edge too.
  assign DataOut = ready ? dout_q : '0;
`else
  assign DataOut = rd_word;
`endif

endmodule

// File: tb/tb_data_mem_param.sv
// Self-checking bench for data_mem_param: default-parameter instance plus a
// NUM_PRESET=0, ADDR_W=4, DATA_W=16 instance sharing clock and reset.
module tb_data_mem_param;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Clear;
  logic        WriteEn;
  logic [7:0]  DataAddress;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;
  logic        Ready;
  logic        WrDropped;

  logic        s_clear;
  logic        s_we;
  logic [3:0]  s_addr;
  logic [15:0] s_din;
  logic [15:0] s_dout;
  logic        s_ready;
  logic        s_dropped;

  int total = 0;
  int bad   = 0;

  // Reference image of the default instance's array.
  int model [256];
  logic exp_dropped;

  always #5 Clk = ~Clk;

  data_mem_param dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Clear       (Clear),
    .WriteEn     (WriteEn),
    .DataAddress (DataAddress),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .Ready       (Ready),
    .WrDropped   (WrDropped)
  );

  data_mem_param #(
    .DATA_W     (16),
    .ADDR_W     (4),
    .NUM_PRESET (0)
  ) dut_small (
    .Clk         (Clk),
    .Reset       (Reset),
    .Clear       (s_clear),
    .WriteEn     (s_we),
    .DataAddress (s_addr),
    .DataIn      (s_din),
    .DataOut     (s_dout),
    .Ready       (s_ready),
    .WrDropped   (s_dropped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory image right after a completed clear+preset sequence.
  task automatic model_init();
    for (int i = 0; i < 256; i++) model[i] = 0;
    model[16]  = 128;
    model[244] = 5;
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    DataAddress = 8'(a);
    WriteEn     = 1'b0;
`ifdef DATAMEM_REGOUT_EN
    @(posedge Clk); #1;
`else
    #1;
`endif
    check(tag, 32'(DataOut), 32'(exp));
  endtask

  task automatic rd_small(input string tag, input int a, input int exp);
    s_addr = 4'(a);
`ifdef DATAMEM_REGOUT_EN
    @(posedge Clk); #1;
`else
    #1;
`endif
    check(tag, 32'(s_dout), 32'(exp));
  endtask

  task automatic wr(input int a, input int d);
    DataAddress = 8'(a);
    DataIn      = 8'(d);
    WriteEn     = 1'b1;
    @(posedge Clk); #1;
    WriteEn     = 1'b0;
    model[a]    = d;
  endtask

  // Counts edges until Ready / s_ready rise, up to a fixed budget.
  task automatic wait_ready(output int big_edge, output int small_edge);
    big_edge   = -1;
    small_edge = -1;
    for (int e = 1; e <= 300; e++) begin
      @(posedge Clk); #1;
      if (Ready && big_edge < 0) big_edge = e;
      if (s_ready && small_edge < 0) small_edge = e;
    end
  endtask

  initial begin
    int re, rs, a, d;
    Reset = 1'b0; Clear = 1'b0; WriteEn = 1'b0; DataAddress = '0; DataIn = '0;
    s_clear = 1'b0; s_we = 1'b0; s_addr = '0; s_din = '0;
    exp_dropped = 1'b0;

    // Reset state.
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ready", 32'(Ready), 0);
    check("rst_dropped", 32'(WrDropped), 0);
    check("rst_dout", 32'(DataOut), 0);
    check("rst_s_ready", 32'(s_ready), 0);

    // Release reset just after an edge so the next edge is init edge 1.
    Reset = 1'b1;
    re = -1; rs = -1;
    for (int e = 1; e <= 300; e++) begin
      @(posedge Clk); #1;
      if (Ready && re < 0) re = e;
      if (s_ready && rs < 0) rs = e;
      if (e == 99) begin
        DataAddress = 8'd3; DataIn = 8'h11; WriteEn = 1'b1;
      end
      if (e == 100) WriteEn = 1'b0;
    end
    exp_dropped = 1'b1;
    model_init();
    check("init_ready_edge", 32'(re), 258);
    check("init_s_ready_edge", 32'(rs), 16);
    check("init_dropped", 32'(WrDropped), 32'(exp_dropped));
    rd("preset0", 16, 128);
    rd("preset1", 244, 5);
    rd("zero_0", 0, 0);
    rd("zero_17", 17, 0);
    rd("zero_255", 255, 0);
    rd("dropped_addr3", 3, 0);
    for (int i = 0; i < 16; i++) rd_small($sformatf("small_%0d", i), i, 0);
    check("small_dropped", 32'(s_dropped), 0);

    // Read-first: old value visible on the write edge, new value afterwards.
    DataAddress = 8'd7; DataIn = 8'hA5; WriteEn = 1'b1;
`ifdef DATAMEM_REGOUT_EN
    @(posedge Clk); #1;
    check("rf_old", 32'(DataOut), 0);
`else
    #1;
    check("rf_old", 32'(DataOut), 0);
    @(posedge Clk); #1;
`endif
    WriteEn = 1'b0;
    model[7] = 8'hA5;
    rd("rf_new", 7, 8'hA5);

    // Randomized traffic against the image.
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        d = int'($urandom_range(0, 255));
        wr(a, d);
      end else begin
        rd($sformatf("rnd_%0d_a%0d", i, a), a, model[a]);
      end
    end
    wr(7, 8'hA5);
    check("rnd_dropped_sticky", 32'(WrDropped), 32'(exp_dropped));

    // Clear pulse: full sequence re-runs from the Clear edge.
    Clear = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0;
    check("clr_ready_low", 32'(Ready), 0);
    check("clr_dout_low", 32'(DataOut), 0);
    wait_ready(re, rs);
    model_init();
    check("clr_ready_edge", 32'(re), 258);
    rd("clr_addr7", 7, model[7]);
    rd("clr_addr16", 16, model[16]);

    // Reset in the middle of init: sequence restarts, flag cleared.
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (50) @(posedge Clk);
    #1;
    Reset = 1'b0;
    exp_dropped = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    wait_ready(re, rs);
    check("rst_mid_ready_edge", 32'(re), 258);
    check("rst_mid_s_ready_edge", 32'(rs), 16);
    check("rst_mid_dropped", 32'(WrDropped), 32'(exp_dropped));
    rd("rst_mid_addr16", 16, 128);
    rd("rst_mid_addr244", 244, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
